// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: MDOp encodings, op-class helpers
// and the countdown width function. Optional feature macro: MDU_MADD_EN.
package mdu_pkg;

   localparam logic [3:0] OpNop   = 4'd0;
   localparam logic [3:0] OpMult  = 4'd1;
   localparam logic [3:0] OpMultu = 4'd2;
   localparam logic [3:0] OpDiv   = 4'd3;
   localparam logic [3:0] OpDivu  = 4'd4;
   localparam logic [3:0] OpMthi  = 4'd5;
   localparam logic [3:0] OpMtlo  = 4'd6;
   localparam logic [3:0] OpMadd  = 4'd7;
   localparam logic [3:0] OpMaddu = 4'd8;
   localparam logic [3:0] OpMsub  = 4'd9;
   localparam logic [3:0] OpMsubu = 4'd10;

   // Counter must be able to hold the longer of the two busy periods.
   function automatic int unsigned cnt_width(input int unsigned mul_cycles,
                                             input int unsigned div_cycles);
      int unsigned longest;
      longest = (mul_cycles > div_cycles) ? mul_cycles : div_cycles;
      return $clog2(longest + 1);
   endfunction

   // Ops that take the multiply busy period.
   function automatic logic is_mul(input logic [3:0] op);
`ifdef MDU_MADD_EN
      return (op == OpMult) || (op == OpMultu) || (op == OpMadd) || (op == OpMaddu) ||
             (op == OpMsub) || (op == OpMsubu);
`else
      return (op == OpMult) || (op == OpMultu);
`endif
   endfunction

   // Ops that take the divide busy period.
   function automatic logic is_div(input logic [3:0] op);
      return (op == OpDiv) || (op == OpDivu);
   endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational result generator for the multiply/divide unit. One shared multiplier and
// one shared magnitude divider serve the signed and unsigned variants.
// Optional feature macro: MDU_MADD_EN (adds the {HI,LO} accumulate/subtract path).
module mdu_calc import mdu_pkg::*; #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] hi,
   input  logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] res_hi,
   output logic [WIDTH-1:0] res_lo,
   output logic             div_zero
);

   localparam int unsigned W2 = 2 * WIDTH;

   logic             mul_signed;
   logic             div_signed;
   logic [W2-1:0]    ext_a;
   logic [W2-1:0]    ext_b;
   logic [W2-1:0]    prod;
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] mag_a;
   logic [WIDTH-1:0] mag_b;
   logic [WIDTH-1:0] div_b;
   logic [WIDTH-1:0] quo_mag;
   logic [WIDTH-1:0] rem_mag;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] rem;

   assign mul_signed = (op == OpMult) || (op == OpMadd) || (op == OpMsub);
   assign div_signed = (op == OpDiv);

   // The low 2*WIDTH bits of a product of sign-extended operands equal the signed product.
   assign ext_a = {{WIDTH{mul_signed & a[WIDTH-1]}}, a};
   assign ext_b = {{WIDTH{mul_signed & b[WIDTH-1]}}, b};
   assign prod  = ext_a * ext_b;

   // Magnitude division; MIN / -1 falls out naturally as quotient MIN, remainder 0.
   assign a_neg   = div_signed & a[WIDTH-1];
   assign b_neg   = div_signed & b[WIDTH-1];
   assign mag_a   = a_neg ? (~a + 1'b1) : a;
   assign mag_b   = b_neg ? (~b + 1'b1) : b;
   assign div_b   = (b == '0) ? WIDTH'(1) : mag_b;
   assign quo_mag = mag_a / div_b;
   assign rem_mag = mag_a % div_b;
   assign quo     = (a_neg ^ b_neg) ? (~quo_mag + 1'b1) : quo_mag;
   assign rem     = a_neg ? (~rem_mag + 1'b1) : rem_mag;

   // Select the result for the current op; anything else passes HI/LO through.
   always_comb begin
      res_hi   = hi;
      res_lo   = lo;
      div_zero = 1'b0;
      case (op)
         OpMult, OpMultu: {res_hi, res_lo} = prod;
         OpDiv, OpDivu: begin
            div_zero = (b == '0);
            res_hi   = rem;
            res_lo   = quo;
         end
`ifdef MDU_MADD_EN
         OpMadd, OpMaddu: {res_hi, res_lo} = {hi, lo} + prod;
         OpMsub, OpMsubu: {res_hi, res_lo} = {hi, lo} - prod;
`endif
         default: ;
      endcase
   end

endmodule

// File: rtl/mult_div_unit.sv
// Multiply/divide unit beside the execute-stage ALU. Owns HI/LO, runs multi-cycle
// MULT/DIV ops through a countdown FSM and commits shadowed results when it expires.
// Optional feature macro: MDU_MADD_EN (codes 7-10 become MADD/MADDU/MSUB/MSUBU).
module mult_div_unit import mdu_pkg::*; #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned MUL_CYCLES = 5,
   parameter int unsigned DIV_CYCLES = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] SrcA_E,
   input  logic [WIDTH-1:0] SrcB_E,
   input  logic [3:0]       MDOp_E,
   input  logic             Start_E,
   input  logic             HiSel_E,
   output logic [WIDTH-1:0] MDOut_E,
   output logic             Busy_E,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   localparam int unsigned CntW = cnt_width(MUL_CYCLES, DIV_CYCLES);

   typedef enum logic {StIdle, StRun} state_t;

   state_t           state_q;
   logic [CntW-1:0]  cnt_q;
   logic             busy_q;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;
   logic [WIDTH-1:0] shadow_hi_q;
   logic [WIDTH-1:0] shadow_lo_q;
   logic             shadow_dz_q;

   logic [WIDTH-1:0] calc_hi;
   logic [WIDTH-1:0] calc_lo;
   logic             calc_dz;
   logic             accept;

   mdu_calc #(
      .WIDTH (WIDTH)
   ) u_calc (
      .a        (SrcA_E),
      .b        (SrcB_E),
      .op       (MDOp_E),
      .hi       (hi_q),
      .lo       (lo_q),
      .res_hi   (calc_hi),
      .res_lo   (calc_lo),
      .div_zero (calc_dz)
   );

   assign accept = Start_E && !busy_q;

   // FSM: accept starts in idle, count down in run, commit shadows on the last cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
         hi_q        <= '0;
         lo_q        <= '0;
         shadow_hi_q <= '0;
         shadow_lo_q <= '0;
         shadow_dz_q <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (accept) begin
                  if (is_mul(MDOp_E) || is_div(MDOp_E)) begin
                     shadow_hi_q <= calc_hi;
                     shadow_lo_q <= calc_lo;
                     shadow_dz_q <= calc_dz;
                     cnt_q       <= is_div(MDOp_E) ? CntW'(DIV_CYCLES) : CntW'(MUL_CYCLES);
                     busy_q      <= 1'b1;
                     state_q     <= StRun;
                  end else if (MDOp_E == OpMthi) begin
                     hi_q <= SrcA_E;
                  end else if (MDOp_E == OpMtlo) begin
                     lo_q <= SrcA_E;
                  end
               end
            end
            StRun: begin
               if (cnt_q == CntW'(1)) begin
                  // Divide by zero burns the full period but leaves HI/LO intact.
                  if (!shadow_dz_q) begin
                     hi_q <= shadow_hi_q;
                     lo_q <= shadow_lo_q;
                  end
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
                  state_q <= StIdle;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign MDOut_E = HiSel_E ? hi_q : lo_q;
   assign Busy_E  = busy_q;
   assign HI      = hi_q;
   assign LO      = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected {HI,LO} per long op,
// a negedge monitor pops and compares when Busy_E falls. Honours MDU_MADD_EN.
module tb_mult_div_unit;
   import mdu_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] SrcA_E = '0;
   logic [31:0] SrcB_E = '0;
   logic [3:0]  MDOp_E = '0;
   logic        Start_E = 1'b0;
   logic        HiSel_E = 1'b0;
   logic [31:0] MDOut_E;
   logic        Busy_E;
   logic [31:0] HI;
   logic [31:0] LO;

   int checks = 0;
   int errors = 0;
   logic [63:0] exp_q[$];

   mult_div_unit #(
      .WIDTH      (32),
      .MUL_CYCLES (5),
      .DIV_CYCLES (10)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .SrcA_E  (SrcA_E),
      .SrcB_E  (SrcB_E),
      .MDOp_E  (MDOp_E),
      .Start_E (Start_E),
      .HiSel_E (HiSel_E),
      .MDOut_E (MDOut_E),
      .Busy_E  (Busy_E),
      .HI      (HI),
      .LO      (LO)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: a falling Busy_E not caused by reset is a commit; compare against the queue.
   logic busy_prev = 1'b0;
   logic reset_prev = 1'b1;
   always @(negedge clk) begin
      if (busy_prev && !Busy_E && !reset_prev) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_commit: got HI=0x%0h LO=0x%0h expected no commit", HI, LO);
         end else begin
            chk("commit_hilo", {HI, LO}, exp_q.pop_front());
         end
      end
      busy_prev = Busy_E;
      reset_prev = reset;
   end

   // Issue a long op, check Busy_E over n cycles; optionally poke an MTHI mid-run.
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int n, input logic [31:0] eh, input logic [31:0] el,
                         input bit poke);
      logic [31:0] hi_before;
      hi_before = HI;
      exp_q.push_back({eh, el});
      @(posedge clk); #1;
      MDOp_E = op; SrcA_E = a; SrcB_E = b; Start_E = 1'b1;
      @(posedge clk); #1;
      Start_E = 1'b0;
      for (int i = 1; i <= n; i++) begin
         @(negedge clk);
         chk("busy_high", {63'd0, Busy_E}, 64'd1);
         if (poke && i == 1) begin
            MDOp_E = OpMthi; SrcA_E = 32'h0000ABCD; Start_E = 1'b1;
         end
         if (poke && i == 2) begin
            Start_E = 1'b0;
            chk("mthi_ignored_busy", {32'd0, HI}, {32'd0, hi_before});
         end
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("busy_low_after", {63'd0, Busy_E}, 64'd0);
   endtask

   task automatic mt(input logic [3:0] op, input logic [31:0] d);
      @(posedge clk); #1;
      MDOp_E = op; SrcA_E = d; Start_E = 1'b1;
      @(posedge clk); #1;
      Start_E = 1'b0;
      @(negedge clk);
      chk("mt_busy", {63'd0, Busy_E}, 64'd0);
      if (op == OpMthi) chk("mthi", {32'd0, HI}, {32'd0, d});
      else              chk("mtlo", {32'd0, LO}, {32'd0, d});
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("reset_hi", {32'd0, HI}, 64'd0);
      chk("reset_lo", {32'd0, LO}, 64'd0);
      chk("reset_busy", {63'd0, Busy_E}, 64'd0);

      run_op(OpMult,  32'hFFFFFFFE, 32'h3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
      run_op(OpMultu, 32'hFFFFFFFE, 32'h3, 5, 32'h00000002, 32'hFFFFFFFA, 1'b0);
      run_op(OpDiv,   32'hFFFFFFF9, 32'h2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
      run_op(OpDiv,   32'h80000000, 32'hFFFFFFFF, 10, 32'h0, 32'h80000000, 1'b0);
      run_op(OpDivu,  32'd100, 32'd7, 10, 32'd2, 32'd14, 1'b0);

      mt(OpMthi, 32'h11);
      mt(OpMtlo, 32'h22);
      #1 HiSel_E = 1'b1;
      #1 chk("mdout_hi", {32'd0, MDOut_E}, 64'h11);
      HiSel_E = 1'b0;
      #1 chk("mdout_lo", {32'd0, MDOut_E}, 64'h22);

      // Divide by zero keeps the previous HI/LO.
      run_op(OpDivu, 32'd7, 32'd0, 10, 32'h11, 32'h22, 1'b0);
      // MTHI during busy is dropped.
      run_op(OpMult, 32'd3, 32'd4, 5, 32'd0, 32'd12, 1'b1);
      chk("hi_not_abcd", {32'd0, HI}, 64'd0);

      // Reset mid-divide aborts with no later commit.
      mt(OpMthi, 32'h55);
      @(posedge clk); #1;
      MDOp_E = OpDiv; SrcA_E = 32'd100; SrcB_E = 32'd3; Start_E = 1'b1;
      @(posedge clk); #1;
      Start_E = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("abort_busy", {63'd0, Busy_E}, 64'd0);
      chk("abort_hilo", {HI, LO}, 64'd0);
      repeat (15) @(posedge clk);
      @(negedge clk);
      chk("abort_no_commit", {HI, LO}, 64'd0);
      chk("abort_idle", {63'd0, Busy_E}, 64'd0);

`ifdef MDU_MADD_EN
      mt(OpMthi, 32'd0);
      mt(OpMtlo, 32'd1);
      run_op(OpMadd,  32'd2, 32'd3, 5, 32'd0, 32'd7, 1'b0);
      run_op(OpMsubu, 32'd1, 32'd8, 5, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
`else
      mt(OpMthi, 32'h33);
      @(posedge clk); #1;
      MDOp_E = OpMadd; SrcA_E = 32'd2; SrcB_E = 32'd3; Start_E = 1'b1;
      @(posedge clk); #1;
      Start_E = 1'b0;
      @(negedge clk);
      chk("reserved_no_busy", {63'd0, Busy_E}, 64'd0);
      repeat (6) @(posedge clk);
      @(negedge clk);
      chk("reserved_no_effect", {HI, LO}, {32'h33, 32'h0});
`endif

      repeat (3) @(posedge clk);
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
